// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined shifter: op encodings and the
// helper that derives the shift-amount width from the operand width.
package pipelined_shifter_pkg;

    typedef enum logic [2:0] {
        OP_LSL = 3'b000,
        OP_LSR = 3'b001,
        OP_ASR = 3'b010,
        OP_ROR = 3'b011,
        OP_ROL = 3'b100
    } op_e;

    localparam int OP_W = 3;

    // Shift-amount width for a power-of-two operand width.
    function automatic int calc_sw(input int w);
        return $clog2(w);
    endfunction

    // Encodings above OP_ROL are reserved.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= 3'(OP_ROL));
    endfunction

endpackage

// File: rtl/pipelined_shifter_shift.sv
// Combinational barrel-shift slice: applies the shift levels LO..LO+NLVL-1
// (shift by 2^k when bit k of the amount is set) for the selected op.
// Reserved ops pass the operand through untouched.
module shift_stage
    import pipelined_shifter_pkg::*;
#(
    parameter int W    = 32,
    parameter int LO   = 0,
    parameter int NLVL = 1
) (
    input  logic [W-1:0]    in_data,
    input  logic [NLVL-1:0] lvl_shamt,
    input  logic [OP_W-1:0] op,
    output logic [W-1:0]    out_data
);

    // One fixed-distance shift or rotate; amt is always in 1..W/2 here.
    function automatic logic [W-1:0] shift_by(input logic [W-1:0]    d,
                                              input logic [OP_W-1:0] sel,
                                              input int              amt);
        logic signed [W-1:0] sd;
        logic [W-1:0]        r;
        sd = d;
        r  = d;
        case (sel)
            OP_LSL:  r = d << amt;
            OP_LSR:  r = d >> amt;
            OP_ASR:  r = sd >>> amt;
            OP_ROR:  r = (d >> amt) | (d << (W - amt));
            OP_ROL:  r = (d << amt) | (d >> (W - amt));
            default: r = d;
        endcase
        return r;
    endfunction

    logic [W-1:0] acc;

    // Cascade the selected power-of-two levels.
    always_comb begin
        acc = in_data;
        for (int i = 0; i < NLVL; i++) begin
            if (lvl_shamt[i]) acc = shift_by(acc, op, 1 << (LO + i));
        end
    end

    assign out_data = acc;

endmodule

// File: rtl/pipelined_shifter.sv
// Two-stage pipelined shifter/rotator with valid/ready handshakes on both
// sides. S1 applies the low half of the shift amount and captures carry and
// error from the original operand; S2 applies the remaining high bits.
module pipelined_shifter
    import pipelined_shifter_pkg::*;
#(
    parameter int W  = 32,
    parameter int SW = calc_sw(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic [SW-1:0]   in_shamt,
    input  logic [OP_W-1:0] in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic            out_carry,
    output logic            out_zero,
    output logic            out_err
);

    localparam int LO_BITS = SW / 2;
    localparam int HI_BITS = SW - LO_BITS;

    // ---- stage 0: combinational front end ----
    logic                 s2_open;
    logic                 in_fire;
    logic                 s1_fire;
    logic [W-1:0]         data_s1;
    logic                 carry_s1;
    logic                 err_s1;
    logic [SW-1:0]        dec_idx;
    logic [SW-1:0]        neg_idx;

    // ---- stage 1 registers ----
    logic                 vld_p1;
    logic [OP_W-1:0]      op_p1;
    logic [W-1:0]         data_p1;
    logic [HI_BITS-1:0]   shamt_hi_p1;
    logic                 carry_p1;
    logic                 err_p1;
    logic [W-1:0]         data_s2;

    // ---- stage 2 registers ----
    logic                 vld_p2;
    logic [W-1:0]         data_p2;
    logic                 carry_p2;
    logic                 err_p2;

    // A stage accepts new contents when empty or when it is draining this cycle.
    assign s2_open  = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_open;
    assign in_fire  = in_valid && in_ready;
    assign s1_fire  = vld_p1 && s2_open;

    shift_stage #(
        .W    (W),
        .LO   (0),
        .NLVL (LO_BITS)
    ) u_stage1 (
        .in_data   (in_data),
        .lvl_shamt (in_shamt[LO_BITS-1:0]),
        .op        (in_op),
        .out_data  (data_s1)
    );

    // W is a power of two, so W-shamt wraps naturally to SW bits.
    assign dec_idx = in_shamt - SW'(1);
    assign neg_idx = SW'(0) - in_shamt;
    assign err_s1  = !is_legal_op(in_op);

    // Carry is the last bit moved out, taken from the unshifted operand.
    always_comb begin
        carry_s1 = 1'b0;
        if (in_shamt != '0) begin
            case (in_op)
                OP_LSL, OP_ROL:         carry_s1 = in_data[neg_idx];
                OP_LSR, OP_ASR, OP_ROR: carry_s1 = in_data[dec_idx];
                default:                carry_s1 = 1'b0;
            endcase
        end
    end

    // Stage valid flags; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready) vld_p1 <= in_valid;
            if (s2_open)  vld_p2 <= vld_p1;
        end
    end

    // ---- S1 capture: low-half shift result plus carry/err ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p1       <= '0;
            data_p1     <= '0;
            shamt_hi_p1 <= '0;
            carry_p1    <= 1'b0;
            err_p1      <= 1'b0;
        end else if (in_fire) begin
            op_p1       <= in_op;
            data_p1     <= data_s1;
            shamt_hi_p1 <= in_shamt[SW-1:LO_BITS];
            carry_p1    <= carry_s1;
            err_p1      <= err_s1;
        end
    end

    shift_stage #(
        .W    (W),
        .LO   (LO_BITS),
        .NLVL (HI_BITS)
    ) u_stage2 (
        .in_data   (data_p1),
        .lvl_shamt (shamt_hi_p1),
        .op        (op_p1),
        .out_data  (data_s2)
    );

    // ---- S2 capture: final result, held while the consumer stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p2  <= '0;
            carry_p2 <= 1'b0;
            err_p2   <= 1'b0;
        end else if (s1_fire) begin
            data_p2  <= data_s2;
            carry_p2 <= carry_p1;
            err_p2   <= err_p1;
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_carry = carry_p2;
    assign out_err   = err_p2;
    assign out_zero  = (data_p2 == '0);

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 Parameter W, default 32: operand width in bits; SHALL be a power of two with 8 <= W <= 64.
REQ-002 Parameter SW, default $clog2(W): shift-amount width in bits; SHALL be derived from W and never overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_data  input  W  operand, signed for ASR.
REQ-008 in_shamt  input  SW  shift amount, 0..W-1.
REQ-009 in_op  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL, 101-111 reserved.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  W  shifted or rotated result.
REQ-013 out_carry  output  1  last bit shifted or rotated out.
REQ-014 out_zero  output  1  high when out_data == 0.
REQ-015 out_err  output  1  request used a reserved op.

Function
REQ-016 A transfer SHALL occur on in_valid && in_ready, and on out_valid && out_ready.
REQ-017 The pipeline SHALL have two register stages (S1, S2); latency from input transfer to out_valid SHALL be exactly 2 cycles when not stalled.
REQ-018 S1 SHALL apply the shamt bits [SW/2-1:0] and S2 SHALL apply the remaining bits; each stage SHALL hold op, partial result, carry and err.
REQ-019 A stage SHALL load when it is empty or its contents advance in the same cycle; in_ready = !S1_valid || S1 advances, giving full throughput of one result per cycle.
REQ-020 While out_valid && !out_ready, out_data, out_carry, out_zero and out_err SHALL hold stable; no request SHALL be dropped or duplicated, and order SHALL be preserved.
REQ-021 LSL and LSR SHALL zero-fill; ASR SHALL replicate in_data[W-1]; ROR and ROL SHALL rotate modulo W.
REQ-022 out_carry SHALL be computed in S1 from the original operand: LSL gives in_data[W-shamt]; LSR and ASR give in_data[shamt-1]; ROR gives result[W-1]; ROL gives result[0].
REQ-023 When shamt == 0: out_data = in_data, out_carry = 0, for every op.
REQ-024 Reserved op: out_data = in_data, out_carry = 0, out_err = 1; out_err SHALL be 0 for legal ops.
REQ-025 out_zero SHALL be derived from the S2 result register, not from the inputs.
REQ-026 Input transfer and output transfer in the same cycle with both stages full SHALL advance both stages with no bubble.

Reset
REQ-027 rst_n low SHALL immediately clear S1_valid and S2_valid, giving out_valid = 0 and in_ready = 1.
REQ-028 Data registers SHALL reset to 0, giving out_data = 0, out_carry = 0, out_err = 0 and out_zero = 1.
REQ-029 Reset during operation SHALL discard all in-flight requests; the first request after rst_n deasserts SHALL produce its result 2 cycles later.

Structure
REQ-030 A shared package SHALL define the op encodings (OP_LSL..OP_ROL) and a function computing the default SW from W.
REQ-031 One sub-module, shift_stage (parametrised W and level range, purely combinational), SHALL be instantiated once per pipeline stage.

Verification (W=8)
REQ-032 LSL 0x81, shamt 1 -> out_data 0x02, out_carry 1, out_zero 0, 2 cycles after the transfer.
REQ-033 ASR 0x80 shamt 3 -> 0xF0, carry 0; LSR 0x80 shamt 7 -> 0x01, carry 0; ROR 0x01 shamt 1 -> 0x80, carry 1.
REQ-034 ROL 0xA5, shamt 0 -> 0xA5, carry 0; op 110 -> 0xA5, out_err 1; LSR 0x01 shamt 1 -> 0x00, out_zero 1, carry 1.
REQ-035 Back-to-back stream of 5 requests with out_ready low for 3 cycles mid-stream -> in_ready drops once 2 requests are held, outputs stay stable while stalled, all 5 results arrive in order with none lost.
REQ-036 rst_n asserted with both stages valid -> out_valid falls immediately with no clock edge; the next request after release -> its result appears 2 cycles later.
